mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-ported DataMemory between two requesters: port 0 is the CPU datapath (fetch and load/store), port 1 is a program loader/DMA engine.
- Sits between the requesters and DataMemory. DataMemory has combinational read and a write on the clock edge.
- Arbitrates round-robin, sequences a fixed-latency access, registers read data and returns a one-cycle ack.
- The CPU FSM holds in its current state until ack0.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles the memory is held per access (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req0  in  1  port 0 request; held until ack0
- we0  in  1  port 0 write enable; stable while req0
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- ack0  out  1  port 0 access complete (1-cycle pulse)
- req1, we1, addr1, wdata1, ack1  same as port 0, for port 1
- rdata  out  DATA_W  registered read data, valid while ackN=1
- mem_addr  out  ADDR_W  to DataMemory address
- mem_we  out  1  to DataMemory writeEnable
- mem_wdata  out  DATA_W  to DataMemory dataIn
- mem_rdata  in  DATA_W  from DataMemory dataOut
- busy  out  1  high in BUSY and RESP
- owner  out  1  port currently or last granted

Behaviour:
- One clock and one reset: clk and reset_n. Reset is asynchronous and active-low.
- Reset values:
  - state=IDLE
  - ack0=ack1=0, mem_we=0, busy=0
  - mem_addr=0, mem_wdata=0, rdata=0
  - owner=1, so port 0 wins the first tie
  - lat_cnt=0
- States:
  - IDLE
    - No request: stay in IDLE.
    - Exactly one req: grant that port.
    - Both req: grant the port != owner.
    - On grant: latch addr/we/wdata into mem_addr/mem_we/mem_wdata, set owner, lat_cnt=MEM_LAT-1, go to BUSY.
  - BUSY
    - mem_addr/mem_wdata are held constant.
    - mem_we is high only in the first BUSY cycle, then 0.
    - If lat_cnt==0: capture mem_rdata into rdata, go to RESP. Otherwise decrement lat_cnt.
  - RESP
    - ack[owner]=1 for exactly this cycle.
    - rdata is held until the next capture; it is captured on writes too.
    - Next state is IDLE. req inputs are ignored in RESP.
- Latency, with req sampled at edge k:
  - BUSY occupies cycles k+1 .. k+MEM_LAT.
  - ack is high in cycle k+MEM_LAT+1.
  - Next grant is possible at the edge ending cycle k+MEM_LAT+2.
  - With MEM_LAT=1, back-to-back throughput is 1 access per 3 cycles.
- Requester rules:
  - The requester deasserts req or presents a new request in the cycle after ack.
  - A req still asserted in IDLE after ack is treated as a new request.
- Fairness: with both ports requesting continuously, grants strictly alternate. Worst-case wait for either port is one foreign access.
- Requests are not cancellable. Dropping req in BUSY does not abort the access; ack is still issued.
- mem_we is never asserted outside BUSY.
- A reset_n assertion mid-access forces IDLE immediately (asynchronously) and clears mem_we, so no partial write occurs after the reset edge. No ack is issued for the aborted access.
- owner changes only on grant.

Decomposition:
- Shared package arb_pkg:
  - state encoding: IDLE=2'd0, BUSY=2'd1, RESP=2'd2; 2'd3 is unreachable and treated as IDLE
  - port index constants PORT_CPU=0, PORT_LD=1
- One natural sub-module, rr_pick2: combinational round-robin chooser.
  - Inputs: req0, req1, owner.
  - Outputs: gnt_valid, gnt_port.
- The FSM, latency counter and output registers stay in the top.

Test Plan:
- Single read: mem holds 0xDEADBEEF at 0x10; req0=1, we0=0, addr0=0x10 at cycle 0 → mem_addr=0x10 in cycle 1, ack0=1 and rdata=0xDEADBEEF in cycle 2, ack1=0 throughout.
- Single write, port 1: req1, we1=1, addr1=0x20, wdata1=0x12345678 → mem_we=1 for exactly one cycle (cycle 1), ack1 in cycle 2; a subsequent port-0 read of 0x20 returns 0x12345678.
- Contention from reset: req0 and req1 both held high → grant order 0,1,0,1 (acks in cycles 2,5,8,11); owner toggles each grant.
- MEM_LAT=3: a read is issued → BUSY for 3 cycles, mem_we low throughout, ack0 in cycle 4, rdata sampled from the last BUSY cycle (change mem_rdata mid-BUSY to check).
- Reset mid-write: reset_n asserted low in the cycle-1 BUSY state → state=IDLE, mem_we=0, ack0/ack1 stay 0; after release, a fresh req0 completes normally with owner starting at 1.
- Drop req during BUSY: req0 deasserted in cycle 1 → ack0 still pulses in cycle 2, then IDLE with no spurious grant.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the DataMemory port arbiter: FSM state encoding and
// requester port indices.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin chooser, purely combinational: a lone requester wins,
// on a tie the port that was not granted last wins.
module rr_pick2
  import arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic owner,
  output logic gnt_valid,
  output logic gnt_port
);

  always_comb begin
    gnt_valid = req0 | req1;
    if (req0 && req1) begin
      gnt_port = ~owner;
    end else if (req1) begin
      gnt_port = PORT_LD;
    end else begin
      gnt_port = PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares single-ported DataMemory between CPU (port 0) and loader/DMA (port 1):
// grant in IDLE, hold the memory MEM_LAT cycles, register read data, pulse ack.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int             CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [CNT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                gnt_valid, gnt_port;

  rr_pick2 u_pick (
    .req0      (req0),
    .req1      (req1),
    .owner     (owner_q),
    .gnt_valid (gnt_valid),
    .gnt_port  (gnt_port)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_cnt_d   = lat_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    mem_we_d    = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    case (state_q)
      BUSY: begin
        if (lat_cnt_q == '0) begin
          rdata_d = mem_rdata;
          state_d = RESP;
          if (owner_q == PORT_CPU) ack0_d = 1'b1;
          else                     ack1_d = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      // IDLE, and the unused encoding 2'd3 which behaves as IDLE
      default: begin
        state_d = IDLE;
        if (gnt_valid) begin
          state_d   = BUSY;
          owner_d   = gnt_port;
          lat_cnt_d = CNT_INIT;
          if (gnt_port == PORT_LD) begin
            mem_addr_d  = addr1;
            mem_we_d    = we1;
            mem_wdata_d = wdata1;
          end else begin
            mem_addr_d  = addr0;
            mem_we_d    = we0;
            mem_wdata_d = wdata0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= PORT_LD;
      lat_cnt_q   <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_cnt_q   <= lat_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;
  assign busy      = (state_q == BUSY) || (state_q == RESP);

endmodule
